line_serdes: RTL

- Parametrised line-to-burst serializer/deserializer between the last-level cache DFP port and the burst memory model (bmem).
- Converts one LINE_WIDTH-bit cache line into BEATS = LINE_WIDTH/BUS_WIDTH bus beats, and back.
- An explicit FSM owns the read and write paths, issues bmem addresses, honours bmem_ready backpressure mid-burst, and filters stray read beats by address.

---
 rtl/line_serdes_if.sv | 48 ++++
 rtl/line_serdes.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/line_serdes_if.sv
// line_serdes_if
//   Bundles the last-level cache DFP port and the burst memory (bmem) port
//   that line_serdes sits between.
//   Modports:
//     slave  - the serdes itself: takes DFP requests and drives bmem.
//     master - the surroundings: cache requester plus the bmem model.
//   Signals (names match the cache/bmem side):
//     dfp_addr/dfp_read/dfp_write/dfp_wdata  request, held until dfp_resp
//     dfp_rdata/dfp_resp                     assembled line, one-cycle done pulse
//     bmem_addr/bmem_read/bmem_write/bmem_wdata  burst request and write beats
//     bmem_ready                             bmem accepts request/beat this cycle
//     bmem_raddr/bmem_rdata/bmem_rvalid      returning read beats, address tagged
`timescale 1ns/1ps
interface line_serdes_if #(
  parameter int LINE_WIDTH = 256,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] dfp_addr;
  logic                  dfp_read;
  logic                  dfp_write;
  logic [LINE_WIDTH-1:0] dfp_wdata;
  logic [LINE_WIDTH-1:0] dfp_rdata;
  logic                  dfp_resp;

  logic [ADDR_WIDTH-1:0] bmem_addr;
  logic                  bmem_read;
  logic                  bmem_write;
  logic [BUS_WIDTH-1:0]  bmem_wdata;
  logic                  bmem_ready;
  logic [ADDR_WIDTH-1:0] bmem_raddr;
  logic [BUS_WIDTH-1:0]  bmem_rdata;
  logic                  bmem_rvalid;

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/line_serdes.sv
// line_serdes
//   Splits one LINE_WIDTH-bit cache line into BEATS = LINE_WIDTH/BUS_WIDTH
//   bmem beats (beat 0 = line bits [BUS_WIDTH-1:0]) and reassembles read
//   beats into a line. One FSM owns both directions.
//   Ports:
//     clk, rst      clock; synchronous active-high reset
//     bus           line_serdes_if.slave (DFP request side + bmem side)
//     dbg_state_o   current FSM state encoding, for observation only
//   Optional build macro: LINE_SERDES_EARLY_WACK_EN
//     Defined: writes are posted. dfp_resp pulses the cycle after the write
//     is latched, the burst drains in the background, new requests stall
//     until the drain ends, and a read of the draining line is answered from
//     the write buffer without a bmem read.
//     Undefined: write dfp_resp follows acceptance of the final beat.
//
//   Handshake: a bmem request (bmem_read) or write beat (bmem_write with
//   bmem_wdata) is transferred in a cycle where it is asserted together with
//   bmem_ready; until then it and its address/data are held stable. Read
//   beats carry no backpressure: a beat exists in any cycle with bmem_rvalid
//   and is only kept in RD_DATA when bmem_raddr equals the latched line
//   address. DFP requests are level-held until the one-cycle dfp_resp.
`timescale 1ns/1ps
module line_serdes #(
  parameter int LINE_WIDTH = 256,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  line_serdes_if.slave      bus,
  output logic [2:0]        dbg_state_o
);
  localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0]      LAST     = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_REQ   = 3'd1,
    S_RD_DATA  = 3'd2,
    S_WR_BURST = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] la_q, la_d;
  logic [LINE_WIDTH-1:0] wbuf_q, wbuf_d;
  logic [LINE_WIDTH-1:0] rbuf_q, rbuf_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
`ifdef LINE_SERDES_EARLY_WACK_EN
  // Posted-write acknowledge pulse, raised on the cycle after IDLE takes a write.
  logic                  post_q, post_d;
`endif

  logic [ADDR_WIDTH-1:0] req_la;
  logic [LINE_WIDTH-1:0] beat_line;

  assign req_la      = bus.dfp_addr & ~OFF_MASK;
  assign dbg_state_o = state_q;
  assign bus.dfp_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      la_q    <= '0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
`ifdef LINE_SERDES_EARLY_WACK_EN
      post_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      la_q    <= la_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
`ifdef LINE_SERDES_EARLY_WACK_EN
      post_q  <= post_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    la_d    = la_q;
    wbuf_d  = wbuf_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
`ifdef LINE_SERDES_EARLY_WACK_EN
    post_d  = 1'b0;
`endif
    bus.dfp_resp   = 1'b0;
    bus.bmem_addr  = '0;
    bus.bmem_read  = 1'b0;
    bus.bmem_write = 1'b0;
    bus.bmem_wdata = '0;

    // Assembly buffer with the incoming beat dropped into slot cnt; used both
    // to update the buffer and, on the last beat, to publish the full line.
    beat_line = rbuf_q;
    beat_line[cnt_q*BUS_WIDTH +: BUS_WIDTH] = bus.bmem_rdata;

    unique case (state_q)
      S_IDLE: begin
        // Read has priority; a write held alongside is taken after the read.
        if (bus.dfp_read) begin
          la_d    = req_la;
          cnt_d   = '0;
          state_d = S_RD_REQ;
        end else if (bus.dfp_write) begin
          la_d    = req_la;
          wbuf_d  = bus.dfp_wdata;
          cnt_d   = '0;
          state_d = S_WR_BURST;
`ifdef LINE_SERDES_EARLY_WACK_EN
          post_d  = 1'b1;
`endif
        end
      end

      S_RD_REQ: begin
        bus.bmem_addr = la_q;
        bus.bmem_read = 1'b1;
        if (bus.bmem_ready) state_d = S_RD_DATA;
      end

      S_RD_DATA: begin
        bus.bmem_addr = la_q;
        if (bus.bmem_rvalid && (bus.bmem_raddr == la_q)) begin
          rbuf_d = beat_line;
          if (cnt_q == LAST) begin
            rdata_d = beat_line;
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_WR_BURST: begin
        bus.bmem_addr  = la_q;
        bus.bmem_write = 1'b1;
        bus.bmem_wdata = wbuf_q[cnt_q*BUS_WIDTH +: BUS_WIDTH];
        if (bus.bmem_ready) begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef LINE_SERDES_EARLY_WACK_EN
            // Write was already acknowledged. A read of this very line that
            // stalled behind the drain is answered from the write buffer.
            if (bus.dfp_read && (req_la == la_q)) begin
              rdata_d = wbuf_q;
              state_d = S_DONE;
            end else begin
              state_d = S_IDLE;
            end
`else
            state_d = S_DONE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        bus.bmem_addr = la_q;
        bus.dfp_resp  = 1'b1;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

`ifdef LINE_SERDES_EARLY_WACK_EN
    if (post_q) bus.dfp_resp = 1'b1;
`endif
  end
endmodule
